// File: rtl/hough_rho_calc_if.sv
// Pixel-in / CORDIC / rho-out signal bundle for the Hough rho calculator.
// slave is the calculator's view; master is the surrounding environment's view.
interface hough_rho_calc_if #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 10,
  parameter int unsigned RHO_W = 11
);
  logic             pix_vld;
  logic             pix_rdy;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [31:0]      phase_out;
  logic             phase_vld;
  logic [31:0]      sin_in;
  logic [31:0]      cos_in;
  logic             trig_vld;
  logic             rho_vld;
  logic [RHO_W-1:0] rho_idx;
  logic [7:0]       theta_idx;
  logic             sweep_done;
  logic             busy;
  logic             err;

  modport slave (
    input  pix_vld, pix_x, pix_y, sin_in, cos_in, trig_vld,
    output pix_rdy, phase_out, phase_vld, rho_vld, rho_idx, theta_idx, sweep_done, busy, err
  );

  modport master (
    output pix_vld, pix_x, pix_y, sin_in, cos_in, trig_vld,
    input  pix_rdy, phase_out, phase_vld, rho_vld, rho_idx, theta_idx, sweep_done, busy, err
  );
endinterface

// File: rtl/hough_rho_calc.sv
// Hough voting front end: sweeps theta per edge pixel, drives the CORDIC with phase words,
// and turns the returned sin/cos pair into an offset, rounded, clamped rho index.
module hough_rho_calc #(
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned THETA_NUM  = 180,
  parameter int unsigned CORDIC_LAT = 18,
  parameter int unsigned RHO_MAX    = 800,
  parameter int unsigned RHO_W      = 11
) (
  input logic             clk,
  input logic             rst_n,
  hough_rho_calc_if.slave bus
);
  localparam int unsigned PX_W = 33 + X_W;
  localparam int unsigned PY_W = 33 + Y_W;
  localparam int unsigned S_W  = ((PX_W > PY_W) ? PX_W : PY_W) + 1;
  localparam logic [7:0]            ThetaLast = 8'(THETA_NUM - 1);
  localparam logic signed [S_W-1:0] RndHalf   = S_W'(32768);
  localparam logic signed [S_W-1:0] RhoOfs    = S_W'(RHO_MAX);
  localparam logic signed [S_W-1:0] RhoTop    = S_W'(2 * RHO_MAX);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e         state_q, state_d;
  logic [7:0]     theta_q, theta_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           pix_rdy_q, pix_rdy_d;
  logic [31:0]    phase_out_q, phase_out_d;
  logic           phase_vld;
  logic           accept;

  // Side channel aligned with the CORDIC result
  logic [CORDIC_LAT-1:0] dly_vld_q;
  logic [X_W-1:0]        dly_x_q     [CORDIC_LAT];
  logic [Y_W-1:0]        dly_y_q     [CORDIC_LAT];
  logic [7:0]            dly_theta_q [CORDIC_LAT];

  logic signed [PX_W-1:0] cos_ext, x_ext, px_c, px_q;
  logic signed [PY_W-1:0] sin_ext, y_ext, py_c, py_q;
  logic signed [S_W-1:0]  sum_c, sum_q, rnd_c, rho_c;
  logic [RHO_W-1:0]       rho_clamp_c;
  logic                   s1_vld_q, s2_vld_q;
  logic [7:0]             s1_theta_q, s2_theta_q;
  logic                   rho_vld_q, sweep_done_q, err_q;
  logic [RHO_W-1:0]       rho_idx_q;
  logic [7:0]             theta_idx_q;

  assign accept    = bus.pix_vld & pix_rdy_q;
  assign phase_vld = (state_q == StSweep);

  // Sweep FSM next state; a pixel accepted at the last theta restarts with no bubble
  always_comb begin
    state_d = state_q;
    theta_d = theta_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSweep;
          theta_d = '0;
          x_d     = bus.pix_x;
          y_d     = bus.pix_y;
        end
      end
      StSweep: begin
        if (theta_q == ThetaLast) begin
          theta_d = '0;
          if (accept) begin
            x_d = bus.pix_x;
            y_d = bus.pix_y;
          end else begin
            state_d = StIdle;
          end
        end else begin
          theta_d = theta_q + 8'd1;
        end
      end
    endcase
    pix_rdy_d   = (state_d == StIdle) | (theta_d == ThetaLast);
    phase_out_d = '0;
    if (state_d == StSweep) begin
      if (theta_d < 8'd90) phase_out_d = {24'd0, theta_d};
      else                 phase_out_d = {14'd0, 2'b01, 8'd0, theta_d - 8'd90};
    end
  end

  // Sweep FSM state and registered CORDIC request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      theta_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_rdy_q   <= 1'b0;
      phase_out_q <= '0;
    end else begin
      state_q     <= state_d;
      theta_q     <= theta_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_rdy_q   <= pix_rdy_d;
      phase_out_q <= phase_out_d;
    end
  end

  // Delay {vld,x,y,theta} by the CORDIC latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_vld_q <= '0;
      for (int i = 0; i < CORDIC_LAT; i++) begin
        dly_x_q[i]     <= '0;
        dly_y_q[i]     <= '0;
        dly_theta_q[i] <= '0;
      end
    end else begin
      dly_vld_q[0]   <= phase_vld;
      dly_x_q[0]     <= x_q;
      dly_y_q[0]     <= y_q;
      dly_theta_q[0] <= theta_q;
      for (int i = 1; i < CORDIC_LAT; i++) begin
        dly_vld_q[i]   <= dly_vld_q[i-1];
        dly_x_q[i]     <= dly_x_q[i-1];
        dly_y_q[i]     <= dly_y_q[i-1];
        dly_theta_q[i] <= dly_theta_q[i-1];
      end
    end
  end

  // Products, sum, and round-half-up with offset and clamp
  always_comb begin
    cos_ext = {{(PX_W-32){bus.cos_in[31]}}, bus.cos_in};
    x_ext   = {{(PX_W-X_W){1'b0}}, dly_x_q[CORDIC_LAT-1]};
    sin_ext = {{(PY_W-32){bus.sin_in[31]}}, bus.sin_in};
    y_ext   = {{(PY_W-Y_W){1'b0}}, dly_y_q[CORDIC_LAT-1]};
    px_c    = cos_ext * x_ext;
    py_c    = sin_ext * y_ext;
    sum_c   = {{(S_W-PX_W){px_q[PX_W-1]}}, px_q} + {{(S_W-PY_W){py_q[PY_W-1]}}, py_q};
    rnd_c   = (sum_q + RndHalf) >>> 16;
    rho_c   = rnd_c + RhoOfs;
    rho_clamp_c = rho_c[RHO_W-1:0];
    if (rho_c[S_W-1])       rho_clamp_c = '0;
    else if (rho_c > RhoTop) rho_clamp_c = RhoTop[RHO_W-1:0];
  end

  // Three datapath stages plus sticky valid-alignment error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_theta_q   <= '0;
      px_q         <= '0;
      py_q         <= '0;
      s2_vld_q     <= 1'b0;
      s2_theta_q   <= '0;
      sum_q        <= '0;
      rho_vld_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      rho_idx_q    <= '0;
      theta_idx_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      s1_vld_q     <= dly_vld_q[CORDIC_LAT-1];
      s1_theta_q   <= dly_theta_q[CORDIC_LAT-1];
      px_q         <= px_c;
      py_q         <= py_c;
      s2_vld_q     <= s1_vld_q;
      s2_theta_q   <= s1_theta_q;
      sum_q        <= sum_c;
      rho_vld_q    <= s2_vld_q;
      sweep_done_q <= s2_vld_q & (s2_theta_q == ThetaLast);
      if (s2_vld_q) begin
        rho_idx_q   <= rho_clamp_c;
        theta_idx_q <= s2_theta_q;
      end
      // Datapath keeps following the delayed valid; mismatch only flags
      err_q <= err_q | (bus.trig_vld ^ dly_vld_q[CORDIC_LAT-1]);
    end
  end

  assign bus.pix_rdy    = pix_rdy_q;
  assign bus.phase_out  = phase_out_q;
  assign bus.phase_vld  = phase_vld;
  assign bus.rho_vld    = rho_vld_q;
  assign bus.rho_idx    = rho_idx_q;
  assign bus.theta_idx  = theta_idx_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != StIdle) | (|dly_vld_q) | s1_vld_q | s2_vld_q | rho_vld_q;
endmodule

// File: tb/tb_hough_rho_calc.sv
// Bench for hough_rho_calc: CORDIC stand-in plus a per-cycle schedule of expected outputs.
module tb_hough_rho_calc;
  localparam int X_W = 10, Y_W = 10, THETA_NUM = 180, CORDIC_LAT = 18;
  localparam int RHO_MAX = 800, RHO_W = 11, LAT = 22;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drop = 1'b0;
  always #5 clk = ~clk;

  hough_rho_calc_if #(.X_W(X_W), .Y_W(Y_W), .RHO_W(RHO_W)) bif ();

  hough_rho_calc #(
    .X_W(X_W), .Y_W(Y_W), .THETA_NUM(THETA_NUM), .CORDIC_LAT(CORDIC_LAT),
    .RHO_MAX(RHO_MAX), .RHO_W(RHO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit live;
  int exp_pt [int];   // cycle -> theta expected on phase_out
  int exp_rt [int];   // cycle -> theta expected on theta_idx
  int exp_rr [int];   // cycle -> expected rho_idx
  int err_from = -1;
  int cap_rho [256];
  logic [31:0] cap_phase [256];
  int run_len = 0, max_run = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
  endtask

  task automatic near(input int act, input int req, input string name);
    chk(act >= req - 1 && act <= req + 1, name, act, req);
  endtask

  function automatic logic [31:0] q16(input real v);
    real t;
    t = v * 65536.0;
    return 32'($rtoi(t >= 0.0 ? t + 0.5 : t - 0.5));
  endfunction

  function automatic logic [31:0] sin_deg(input int d); return q16($sin(d * PI / 180.0)); endfunction
  function automatic logic [31:0] cos_deg(input int d); return q16($cos(d * PI / 180.0)); endfunction

  function automatic int deg_of(input logic [31:0] p);
    return int'(p[17:16]) * 90 + int'(p[15:0]);
  endfunction

  function automatic logic [31:0] phase_of(input int t);
    return (t < 90) ? 32'(t) : 32'h0001_0000 + 32'(t - 90);
  endfunction

  function automatic int ref_rho(input int x, input int y, input int t);
    longint c, s, sum, r;
    c = longint'($signed(cos_deg(t)));
    s = longint'($signed(sin_deg(t)));
    sum = c * x + s * y;
    r = ((sum + 32768) >>> 16) + RHO_MAX;
    if (r < 0) r = 0;
    if (r > 2 * RHO_MAX) r = 2 * RHO_MAX;
    return int'(r);
  endfunction

  // CORDIC stand-in: exact rounded sin/cos, fixed latency
  logic [31:0] c_sin [CORDIC_LAT];
  logic [31:0] c_cos [CORDIC_LAT];
  logic        c_vld [CORDIC_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORDIC_LAT; i++) begin
        c_sin[i] <= '0; c_cos[i] <= '0; c_vld[i] <= 1'b0;
      end
    end else begin
      c_vld[0] <= bif.phase_vld;
      c_sin[0] <= sin_deg(deg_of(bif.phase_out));
      c_cos[0] <= cos_deg(deg_of(bif.phase_out));
      for (int i = 1; i < CORDIC_LAT; i++) begin
        c_vld[i] <= c_vld[i-1]; c_sin[i] <= c_sin[i-1]; c_cos[i] <= c_cos[i-1];
      end
    end
  end
  assign bif.sin_in   = c_sin[CORDIC_LAT-1];
  assign bif.cos_in   = c_cos[CORDIC_LAT-1];
  assign bif.trig_vld = c_vld[CORDIC_LAT-1] & ~drop;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Compare process: every cycle against the schedule
  always @(negedge clk) begin : compare
    int n, t;
    bit pv, rv, busy_exp, err_exp;
    n = cyc;
    if (!rst_n) begin
      chk(!bif.rho_vld && !bif.pix_rdy && !bif.phase_vld && !bif.busy && !bif.err &&
          !bif.sweep_done && bif.rho_idx == '0 && bif.theta_idx == '0 && bif.phase_out == '0,
          "reset_zero", {bif.rho_vld, bif.pix_rdy, bif.phase_vld, bif.busy, bif.err}, 0);
      exp_pt.delete(); exp_rt.delete(); exp_rr.delete();
      err_from = -1;
    end else if (live) begin
      pv = exp_pt.exists(n);
      if (pv) begin
        chk(bif.phase_vld && bif.phase_out == phase_of(exp_pt[n]), "phase_out",
            bif.phase_out, phase_of(exp_pt[n]));
        cap_phase[exp_pt[n]] = bif.phase_out;
        chk(bif.pix_rdy == (exp_pt[n] == THETA_NUM - 1), "pix_rdy_sweep", bif.pix_rdy,
            exp_pt[n] == THETA_NUM - 1);
      end else begin
        chk(!bif.phase_vld, "phase_vld_idle", bif.phase_vld, 0);
        chk(bif.pix_rdy, "pix_rdy_idle", bif.pix_rdy, 1);
      end
      rv = exp_rt.exists(n);
      if (rv) begin
        t = exp_rt[n];
        chk(bif.rho_vld && int'(bif.rho_idx) == exp_rr[n] && int'(bif.theta_idx) == t,
            "rho", {bif.rho_vld, bif.theta_idx, bif.rho_idx}, {1'b1, 8'(t), 11'(exp_rr[n])});
        chk(bif.sweep_done == (t == THETA_NUM - 1), "sweep_done", bif.sweep_done,
            t == THETA_NUM - 1);
        cap_rho[t] = int'(bif.rho_idx);
      end else begin
        chk(!bif.rho_vld && !bif.sweep_done, "rho_vld_idle", bif.rho_vld, 0);
      end
      run_len = bif.rho_vld ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      busy_exp = 1'b0;
      for (int k = 0; k < LAT; k++) if (exp_pt.exists(n - k)) busy_exp = 1'b1;
      chk(bif.busy == busy_exp, "busy", bif.busy, busy_exp);
      err_exp = (err_from >= 0) && (n >= err_from);
      chk(bif.err == err_exp, "err", bif.err, err_exp);
      if (drop && c_vld[CORDIC_LAT-1] && err_from < 0) err_from = n + 1;
      if (bif.pix_vld && bif.pix_rdy) begin
        for (int k = 0; k < THETA_NUM; k++) begin
          exp_pt[n + 1 + k]   = k;
          exp_rt[n + LAT + k] = k;
          exp_rr[n + LAT + k] = ref_rho(int'(bif.pix_x), int'(bif.pix_y), k);
        end
      end
    end
  end

  task automatic send_pixel(input int x, input int y, input bit keep);
    int i;
    @(posedge clk); #1;
    bif.pix_vld = 1'b1;
    bif.pix_x   = X_W'(x);
    bif.pix_y   = Y_W'(y);
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bif.pix_rdy) break;
    end
    if (i == 500) chk(1'b0, "accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) bif.pix_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bif.busy) break;
    end
    if (i == 600) chk(1'b0, "idle_timeout", 1, 0);
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 256; i++) begin cap_rho[i] = -1; cap_phase[i] = '1; end
    max_run = 0;
  endtask

  task automatic check_all_800(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < THETA_NUM; i++) if (cap_rho[i] != RHO_MAX) bad++;
    chk(bad == 0, name, bad, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bif.pix_vld = 1'b0;
    bif.pix_x   = '0;
    bif.pix_y   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the reference model to hand-computed values
    chk(ref_rho(100, 0, 0) == 900, "model_100_0_th0", ref_rho(100, 0, 0), 900);
    chk(ref_rho(100, 0, 179) == 700, "model_100_0_th179", ref_rho(100, 0, 179), 700);
    chk(ref_rho(0, 100, 90) == 900, "model_0_100_th90", ref_rho(0, 100, 90), 900);
    chk(phase_of(135) == 32'h0001_002D, "model_phase135", phase_of(135), 32'h0001_002D);

    // Pixel at origin
    clear_cap();
    send_pixel(0, 0, 1'b0);
    wait_idle();
    check_all_800("origin_all_800");
    chk(max_run == THETA_NUM, "origin_run", max_run, THETA_NUM);

    // x only
    clear_cap();
    send_pixel(100, 0, 1'b0);
    wait_idle();
    near(cap_rho[0], 900, "x100_th0");
    near(cap_rho[90], 800, "x100_th90");
    near(cap_rho[179], 700, "x100_th179");
    chk(cap_phase[135] == 32'h0001_002D, "phase_th135", cap_phase[135], 32'h0001_002D);

    // y only, then far corner
    clear_cap();
    send_pixel(0, 100, 1'b0);
    wait_idle();
    near(cap_rho[0], 800, "y100_th0");
    near(cap_rho[90], 900, "y100_th90");
    clear_cap();
    send_pixel(639, 479, 1'b0);
    wait_idle();
    near(cap_rho[37], 1599, "corner_th37");

    // Back-to-back pixels
    clear_cap();
    send_pixel(10, 20, 1'b1);
    send_pixel(300, 200, 1'b0);
    wait_idle();
    chk(max_run == 2 * THETA_NUM, "b2b_run", max_run, 2 * THETA_NUM);

    // Reset mid-sweep at theta 50, then origin again
    send_pixel(5, 7, 1'b0);
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    clear_cap();
    send_pixel(0, 0, 1'b0);
    wait_idle();
    check_all_800("post_reset_all_800");

    // Random pixels with random gaps or back-to-back
    for (int i = 0; i < 6; i++) begin
      bit keep;
      keep = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_pixel(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), keep);
      if (!keep) repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    wait_idle();

    // Clamp at both ends
    clear_cap();
    send_pixel(1023, 1023, 1'b0);
    wait_idle();
    chk(cap_rho[45] == 2 * RHO_MAX, "clamp_high", cap_rho[45], 2 * RHO_MAX);
    chk(cap_rho[179] == 0, "clamp_low", cap_rho[179], 0);

    // Dropped trig_vld: err goes sticky, data unaffected
    send_pixel(50, 60, 1'b0);
    repeat (30) @(posedge clk);
    #1 drop = 1'b1;
    @(posedge clk);
    #1 drop = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk(bif.err == 1'b1, "err_sticky", bif.err, 1);
    do_reset();
    repeat (5) @(negedge clk);
    chk(bif.err == 1'b0, "err_cleared", bif.err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
